// File: rtl/gerenciador_contexto_if.sv
// Bundle between program memory, preemption timer and fetch/PC stage.
// master drives memory/timer/regfile inputs; slave is the context manager.
interface gerenciador_contexto_if #(
  parameter int LARG_CONT = 16
);
  logic [31:0]          instr_mem;
  logic [31:0]          instr_temp;
  logic                 flag_pausa;
  logic [31:0]          pc_atual;
  logic [31:0]          reg_a_dado;
  logic [31:0]          reg_b_dado;
  logic [31:0]          instrucao;
  logic                 congela_pc;
  logic                 desvio;
  logic [31:0]          end_desvio;
  logic [31:0]          contexto;
  logic [31:0]          pc_salvo;
  logic [31:0]          pc_retomada;
  logic                 erro_contexto;
  logic [LARG_CONT-1:0] contador_trocas;

  modport master (
    output instr_mem, instr_temp, flag_pausa,
    output pc_atual, reg_a_dado, reg_b_dado,
    input  instrucao, congela_pc, desvio,
    input  end_desvio, contexto, pc_salvo,
    input  pc_retomada, erro_contexto,
    input  contador_trocas
  );

  modport slave (
    input  instr_mem, instr_temp, flag_pausa,
    input  pc_atual, reg_a_dado, reg_b_dado,
    output instrucao, congela_pc, desvio,
    output end_desvio, contexto, pc_salvo,
    output pc_retomada, erro_contexto,
    output contador_trocas
  );
endinterface

// File: rtl/gerenciador_contexto.sv
// Context-switch manager: selects memory or timer-injected instruction,
// freezes PC while injecting, saves preempted PCs, runs the context branch.
// Ports: clk, reset (async, active-high), bus (gerenciador_contexto_if.slave).
module gerenciador_contexto #(
  parameter int         NUM_CONTEXTOS = 8,
  parameter logic [5:0] OP_TROCA      = 6'b111111,
  parameter int         LARG_CONT     = 16
) (
  input logic             clk,
  input logic             reset,
  gerenciador_contexto_if.slave bus
);
  localparam int IW = $clog2(NUM_CONTEXTOS);

  typedef enum logic [1:0] {
    EXEC,
    INJETA,
    DESVIO
  } estado_t;

  estado_t              estado;
  logic                 pausa_d;
  logic                 desvio;
  logic                 erro;
  logic [31:0]          end_desvio;
  logic [31:0]          contexto;
  logic [31:0]          pc_salvo;
  logic [LARG_CONT-1:0] contador;
  logic [31:0]          tabela_pc [NUM_CONTEXTOS];

  logic [31:0]          instrucao;
  logic                 borda;
  logic                 eh_troca;
  logic                 ctx_ok;
  logic                 faz_troca;
  logic                 congela;
  logic [IW-1:0]        idx_atual;
  logic [IW-1:0]        idx_ret;

  assign instrucao = bus.flag_pausa ? bus.instr_temp
                                    : bus.instr_mem;
  assign borda     = bus.flag_pausa & ~pausa_d;
  assign eh_troca  = instrucao[31:26] == OP_TROCA;
  assign ctx_ok    = bus.reg_b_dado < 32'(NUM_CONTEXTOS);
  assign idx_atual = contexto[IW-1:0];
  assign idx_ret   = bus.reg_b_dado[IW-1:0];

  // A pause edge in EXEC outranks a switch opcode in memory;
  // the muxed word is instr_temp then anyway.
  always_comb begin
    faz_troca = 1'b0;
    unique case (1'b1)
      estado == EXEC:   faz_troca = eh_troca & ~borda;
      estado == INJETA: faz_troca = eh_troca;
      default:          faz_troca = 1'b0;
    endcase
  end

  // Reset forces the freeze low at once, even if the timer
  // still holds its pause flag.
  always_comb begin
    congela = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        estado == EXEC:   congela = bus.flag_pausa;
        estado == INJETA: congela = 1'b1;
        default:          congela = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= EXEC;
      pausa_d    <= 1'b0;
      desvio     <= 1'b0;
      erro       <= 1'b0;
      end_desvio <= '0;
      contexto   <= '0;
      pc_salvo   <= '0;
      contador   <= '0;
      for (int i = 0; i < NUM_CONTEXTOS; i++)
        tabela_pc[i] <= '0;
    end else begin
      // pausa_d also tracks during DESVIO, so an edge
      // arriving there is consumed without capture.
      pausa_d <= bus.flag_pausa;
      desvio  <= 1'b0;
      erro    <= 1'b0;
      if (faz_troca) begin
        if (ctx_ok) begin
          end_desvio <= bus.reg_a_dado;
          contexto   <= bus.reg_b_dado;
          desvio     <= 1'b1;
          estado     <= DESVIO;
          if (contador != '1)
            contador <= contador + 1'b1;
        end else begin
          erro   <= 1'b1;
          estado <= EXEC;
        end
      end else begin
        unique case (estado)
          EXEC: begin
            if (borda) begin
              estado               <= INJETA;
              pc_salvo             <= bus.pc_atual;
              tabela_pc[idx_atual] <= bus.pc_atual;
            end
          end
          INJETA: begin
            if (!bus.flag_pausa)
              estado <= EXEC;
          end
          DESVIO: estado <= EXEC;
          default: estado <= EXEC;
        endcase
      end
    end
  end

  assign bus.instrucao       = instrucao;
  assign bus.congela_pc      = congela;
  assign bus.desvio          = desvio;
  assign bus.end_desvio      = end_desvio;
  assign bus.contexto        = contexto;
  assign bus.pc_salvo        = pc_salvo;
  assign bus.pc_retomada     = tabela_pc[idx_ret];
  assign bus.erro_contexto   = erro;
  assign bus.contador_trocas = contador;
endmodule
